// File: rtl/puf_challenge_sender.sv
// Initiator side of the UART PUF challenge/response link: serialises a challenge LSB-first
// through the uart transmit handshake, then waits for the one-byte response.
// Optional feature macro PUF_TX_CHECKSUM_EN appends an XOR checksum byte to the challenge.
module puf_challenge_sender #(
  parameter int unsigned num_bytes      = 8,
  parameter int unsigned timeout_cycles = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*num_bytes-1:0] challenge,
  output logic                   busy,
  output logic                   done,
  output logic                   resp_valid,
  output logic                   resp_bit,
  output logic [1:0]             err,
  output logic                   uart_transmit,
  output logic [7:0]             uart_tx_byte,
  input  logic                   uart_is_transmitting,
  input  logic                   uart_received,
  input  logic [7:0]             uart_rx_byte,
  input  logic                   uart_recv_error
);

  localparam int unsigned IdxW = $clog2(num_bytes + 1);
  localparam int unsigned CntW = $clog2(timeout_cycles + 1);
  // The wait ends once the counter's next value would reach timeout_cycles-1.
  localparam logic [CntW-1:0] CntLast = CntW'(timeout_cycles - 2);
`ifdef PUF_TX_CHECKSUM_EN
  localparam logic [IdxW-1:0] LastIdx = IdxW'(num_bytes);
`else
  localparam logic [IdxW-1:0] LastIdx = IdxW'(num_bytes - 1);
`endif

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrTxStall  = 2'b01;
  localparam logic [1:0] ErrRespTo   = 2'b10;
  localparam logic [1:0] ErrRecvErr  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitTxHi,
    StWaitTxLo,
    StWaitResp,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [8*num_bytes-1:0] chal_q, chal_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_bit_q, resp_bit_d;
  logic [1:0]             err_q, err_d;
  logic                   cnt_hit;
  logic [7:0]             sel_byte;

  assign cnt_hit = (cnt_q >= CntLast);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    chal_d       = chal_q;
    resp_valid_d = resp_valid_q;
    resp_bit_d   = resp_bit_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          chal_d       = challenge;
          resp_valid_d = 1'b0;
          resp_bit_d   = 1'b0;
          err_d        = ErrOk;
          idx_d        = '0;
          state_d      = StSend;
        end
      end
      StSend: state_d = StWaitTxHi;
      StWaitTxHi: begin
        if (uart_is_transmitting) begin
          state_d = StWaitTxLo;
        end else if (cnt_hit) begin
          err_d   = ErrTxStall;
          state_d = StDone;
        end
      end
      StWaitTxLo: begin
        if (!uart_is_transmitting) begin
          if (idx_q == LastIdx) begin
            state_d = StWaitResp;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StSend;
          end
        end else if (cnt_hit) begin
          err_d   = ErrTxStall;
          state_d = StDone;
        end
      end
      StWaitResp: begin
        if (uart_recv_error) begin
          err_d   = ErrRecvErr;
          state_d = StDone;
        end else if (uart_received) begin
          resp_bit_d   = uart_rx_byte[0];
          resp_valid_d = 1'b1;
          state_d      = StDone;
        end else if (cnt_hit) begin
          err_d   = ErrRespTo;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte for the next SEND; an index of num_bytes selects the checksum when enabled.
  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < num_bytes; i++) begin
      if (idx_d == IdxW'(i)) sel_byte = chal_q[8*i +: 8];
    end
`ifdef PUF_TX_CHECKSUM_EN
    if (idx_d == IdxW'(num_bytes)) begin
      sel_byte = 8'h00;
      for (int i = 0; i < num_bytes; i++) sel_byte = sel_byte ^ chal_q[8*i +: 8];
    end
`endif
  end

  always_comb begin
    tx_byte_d = tx_byte_q;
    if (state_d == StSend) begin
      tx_byte_d = (state_q == StIdle) ? challenge[7:0] : sel_byte;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StWaitTxHi || state_q == StWaitTxLo || state_q == StWaitResp) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      chal_q       <= '0;
      tx_byte_q    <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      err_q        <= ErrOk;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      chal_q       <= chal_d;
      tx_byte_q    <= tx_byte_d;
      resp_valid_q <= resp_valid_d;
      resp_bit_q   <= resp_bit_d;
      err_q        <= err_d;
    end
  end

  assign busy          = (state_q == StSend) || (state_q == StWaitTxHi) ||
                         (state_q == StWaitTxLo) || (state_q == StWaitResp);
  assign done          = (state_q == StDone);
  assign uart_transmit = (state_q == StSend);
  assign uart_tx_byte  = tx_byte_q;
  assign resp_valid    = resp_valid_q;
  assign resp_bit      = resp_bit_q;
  assign err           = err_q;

endmodule

// File: tb/tb_puf_challenge_sender.sv
// Scoreboard bench for puf_challenge_sender with a small behavioural uart model.
module tb_puf_challenge_sender;
  localparam int NB = 8;
  localparam int TO = 50;
`ifdef PUF_TX_CHECKSUM_EN
  localparam int NTX = NB + 1;
`else
  localparam int NTX = NB;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   challenge = '0;
  logic          busy, done, resp_valid, resp_bit, uart_transmit;
  logic [1:0]    err;
  logic [7:0]    uart_tx_byte;
  logic          uart_is_transmitting = 1'b0;
  logic          uart_received = 1'b0;
  logic [7:0]    uart_rx_byte = 8'h00;
  logic          uart_recv_error = 1'b0;

  puf_challenge_sender #(
    .num_bytes     (NB),
    .timeout_cycles(TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .challenge           (challenge),
    .busy                (busy),
    .done                (done),
    .resp_valid          (resp_valid),
    .resp_bit            (resp_bit),
    .err                 (err),
    .uart_transmit       (uart_transmit),
    .uart_tx_byte        (uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_received       (uart_received),
    .uart_rx_byte        (uart_rx_byte),
    .uart_recv_error     (uart_recv_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] err;
    logic       valid;
    logic       rbit;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   tx_seen = 0;
  int   done_seen = 0;
  int   frames = 0;
  int   first_tx_cyc = -1;
  int   done_cyc = -1;
  bit   never_hi = 1'b0;
  logic [7:0] exp_byte_q[$];
  res_t       exp_res_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [63:0] c, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      x = x ^ c[8*i +: 8];
      if (i < n) exp_byte_q.push_back(c[8*i +: 8]);
    end
`ifdef PUF_TX_CHECKSUM_EN
    if (n == NB) exp_byte_q.push_back(x);
`endif
  endtask

  task automatic push_res(input logic [1:0] e, input logic v, input logic b);
    res_t r;
    r.err = e;
    r.valid = v;
    r.rbit = b;
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_start(input logic [63:0] c);
    challenge = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_frames(input int n);
    int b;
    b = 0;
    while (frames < n && b < 1000) begin
      tick();
      b++;
    end
    chk("frames_sent", frames, n);
  endtask

  task automatic wait_done(input int base);
    int b;
    b = 0;
    while (done_seen <= base && b < 1000) begin
      tick();
      b++;
    end
    chk("done_count", done_seen, base + 1);
  endtask

  task automatic send_resp(input logic [7:0] rx, input logic recv, input logic rerr);
    repeat (3) tick();
    uart_rx_byte = rx;
    uart_received = recv;
    uart_recv_error = rerr;
    tick();
    uart_received = 1'b0;
    uart_recv_error = 1'b0;
  endtask

  initial begin
    int d0;
    int t0;
    int b;
    fork
      // uart model: each transmit pulse becomes a short frame on is_transmitting
      forever begin
        @(negedge clk);
        if (uart_transmit && !never_hi) begin
          repeat (2) @(negedge clk);
          uart_is_transmitting = 1'b1;
          repeat (4) @(negedge clk);
          uart_is_transmitting = 1'b0;
          frames++;
        end
      end
      // monitor: pop and compare on every transmit pulse and done pulse
      forever begin
        @(negedge clk);
        if (uart_transmit) begin
          tx_seen++;
          if (first_tx_cyc < 0) first_tx_cyc = cyc;
          if (exp_byte_q.size() == 0) begin
            chk("tx_unexpected", {56'h0, uart_tx_byte}, 64'hFFFF);
          end else begin
            chk("tx_byte", uart_tx_byte, exp_byte_q.pop_front());
          end
        end
        if (done) begin
          done_seen++;
          done_cyc = cyc;
          if (exp_res_q.size() == 0) begin
            chk("done_unexpected", done, 0);
          end else begin
            res_t r;
            r = exp_res_q.pop_front();
            chk("done_err", err, r.err);
            chk("done_resp_valid", resp_valid, r.valid);
            chk("done_resp_bit", resp_bit, r.rbit);
            chk("done_busy", busy, 0);
          end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_bit", resp_bit, 0);
    chk("rst_err", err, 0);
    chk("rst_transmit", uart_transmit, 0);
    chk("rst_tx_byte", uart_tx_byte, 0);
    rst = 1'b0;
    tick();

    // response 0x31 -> bit 1; a start while busy must be ignored
    frames = 0;
    push_bytes(64'h0123456789ABCDEF, NB);
    push_res(2'b00, 1'b1, 1'b1);
    d0 = done_seen;
    pulse_start(64'h0123456789ABCDEF);
    tick();
    challenge = 64'hDEADBEEFCAFEF00D;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frames(NTX);
    send_resp(8'h31, 1'b1, 1'b0);
    wait_done(d0);
    repeat (3) tick();
    chk("held_resp_valid", resp_valid, 1);
    chk("held_resp_bit", resp_bit, 1);
    chk("idle_busy", busy, 0);
    chk("bytes_all_sent", exp_byte_q.size(), 0);

    // is_transmitting never rises: tx stall timeout TO cycles after the transmit pulse
    never_hi = 1'b1;
    first_tx_cyc = -1;
    push_bytes(64'h0123456789ABCDEF, 1);
    push_res(2'b01, 1'b0, 1'b0);
    d0 = done_seen;
    pulse_start(64'h0123456789ABCDEF);
    wait_done(d0);
    chk("tx_timeout_latency", done_cyc - first_tx_cyc, TO);
    never_hi = 1'b0;
    repeat (3) tick();

    // response 0xA4 -> bit 0; stale rx pulses during the send phase are ignored
    frames = 0;
    push_bytes(64'h0123456789ABCDEF, NB);
    push_res(2'b00, 1'b1, 1'b0);
    d0 = done_seen;
    pulse_start(64'h0123456789ABCDEF);
    wait_frames(2);
    uart_rx_byte = 8'h01;
    uart_received = 1'b1;
    uart_recv_error = 1'b1;
    tick();
    uart_received = 1'b0;
    uart_recv_error = 1'b0;
    wait_frames(NTX);
    send_resp(8'hA4, 1'b1, 1'b0);
    wait_done(d0);
    repeat (3) tick();

    // no response byte: response timeout
    frames = 0;
    push_bytes(64'h0F1E2D3C4B5A6978, NB);
    push_res(2'b10, 1'b0, 1'b0);
    d0 = done_seen;
    pulse_start(64'h0F1E2D3C4B5A6978);
    wait_frames(NTX);
    wait_done(d0);
    repeat (3) tick();

    // received and recv_error together: error wins
    frames = 0;
    push_bytes(64'h8000000000000001, NB);
    push_res(2'b11, 1'b0, 1'b0);
    d0 = done_seen;
    pulse_start(64'h8000000000000001);
    wait_frames(NTX);
    send_resp(8'h31, 1'b1, 1'b1);
    wait_done(d0);
    repeat (3) tick();

    // reset during byte 3, then a fresh run
    frames = 0;
    push_bytes(64'h0123456789ABCDEF, NB);
    d0 = done_seen;
    t0 = tx_seen;
    pulse_start(64'h0123456789ABCDEF);
    b = 0;
    while (tx_seen < t0 + 3 && b < 500) begin
      tick();
      b++;
    end
    chk("abort_point_reached", tx_seen, t0 + 3);
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_transmit", uart_transmit, 0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("abort_no_done", done_seen, d0);
    chk("abort_resp_valid", resp_valid, 0);
    exp_byte_q.delete();
    frames = 0;
    push_bytes(64'hFFFFFFFF00000000, NB);
    push_res(2'b00, 1'b1, 1'b1);
    pulse_start(64'hFFFFFFFF00000000);
    wait_frames(NTX);
    send_resp(8'h31, 1'b1, 1'b0);
    wait_done(d0);
    repeat (3) tick();

    chk("final_bytes_empty", exp_byte_q.size(), 0);
    chk("final_results_empty", exp_res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
